neuron_mac_ctrl: RTL

NEURON_MAC_CTRL -- requirements
Module: neuron_mac_ctrl

---
 rtl/neuron_mac_ctrl_if.sv | 30 +++
 rtl/neuron_mac_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/neuron_mac_ctrl_if.sv
// Handshake and shared-ALU bundle between the neuron MAC controller and its environment.
// The master side is the environment (data source, result sink, combinational ALU).
interface neuron_mac_ctrl_if;
  logic        start;
  logic [31:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in;
  logic [31:0] w_in;
  logic [3:0]  alu_op;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [31:0] alu_result;
  logic        alu_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y_out;
  logic        ovf_out;
  logic        busy;

  modport master (
    output start, bias, in_valid, x_in, w_in, out_ready, alu_result, alu_ovf,
    input  in_ready, alu_op, alu_op1, alu_op2, out_valid, y_out, ovf_out, busy
  );

  modport slave (
    input  start, bias, in_valid, x_in, w_in, out_ready, alu_result, alu_ovf,
    output in_ready, alu_op, alu_op1, alu_op2, out_valid, y_out, ovf_out, busy
  );
endinterface

// File: rtl/neuron_mac_ctrl.sv
// Dot-product controller: bias + sum(x*w) over N_INPUTS pairs, sequenced through a
// shared external combinational ALU (multiply, then accumulate) with a sticky overflow flag.
module neuron_mac_ctrl #(
  parameter int N_INPUTS = 4
) (
  input  logic             clk,
  input  logic             rst,
  neuron_mac_ctrl_if.slave bus
);

  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_MULT = 4'b0110;
  localparam logic [7:0] LAST    = 8'(N_INPUTS - 1);

  typedef enum logic [2:0] {IDLE, WAIT_IN, MUL, ADD, DONE} state_t;

  state_t      r_state;
  logic [31:0] r_acc;
  logic [31:0] r_prod;
  logic [31:0] r_x;
  logic [31:0] r_w;
  logic [7:0]  r_cnt;
  logic        r_ovfSticky;
  logic        r_inReady;
  logic        r_outValid;
  logic        r_busy;

  logic [3:0]  w_aluOp;
  logic [31:0] w_aluOp1;
  logic [31:0] w_aluOp2;

  // Handshake flags are set on the transition into their state, so none depends on a live input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_prod      <= '0;
      r_x         <= '0;
      r_w         <= '0;
      r_cnt       <= '0;
      r_ovfSticky <= 1'b0;
      r_inReady   <= 1'b0;
      r_outValid  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_acc       <= bus.bias;
            r_cnt       <= '0;
            r_ovfSticky <= 1'b0;
            r_inReady   <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= WAIT_IN;
          end
        end
        WAIT_IN: begin
          if (bus.in_valid && r_inReady) begin
            r_x       <= bus.x_in;
            r_w       <= bus.w_in;
            r_inReady <= 1'b0;
            r_state   <= MUL;
          end
        end
        MUL: begin
          r_prod      <= bus.alu_result;
          r_ovfSticky <= r_ovfSticky | bus.alu_ovf;
          r_state     <= ADD;
        end
        ADD: begin
          r_acc       <= bus.alu_result;
          r_ovfSticky <= r_ovfSticky | bus.alu_ovf;
          if (r_cnt == LAST) begin
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_cnt     <= r_cnt + 8'd1;
            r_inReady <= 1'b1;
            r_state   <= WAIT_IN;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_inReady  <= 1'b0;
          r_outValid <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  // The ALU is idled as an add of zeros whenever the controller is not using it.
  always_comb begin
    w_aluOp  = OP_ADD;
    w_aluOp1 = '0;
    w_aluOp2 = '0;
    case (r_state)
      MUL: begin
        w_aluOp  = OP_MULT;
        w_aluOp1 = r_x;
        w_aluOp2 = r_w;
      end
      ADD: begin
        w_aluOp1 = r_acc;
        w_aluOp2 = r_prod;
      end
      default: ;
    endcase
  end

  assign bus.alu_op    = w_aluOp;
  assign bus.alu_op1   = w_aluOp1;
  assign bus.alu_op2   = w_aluOp2;
  assign bus.in_ready  = r_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.busy      = r_busy;
  assign bus.y_out     = r_acc;
  assign bus.ovf_out   = r_ovfSticky;

endmodule
